// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART transmit path: parity modes,
// transmitter state encoding, baud divider and parity helpers.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    // Clock cycles per bit, rounded to nearest.
    function automatic int calc_div(input int clk_freq, input int baud);
        return (clk_freq + baud / 2) / baud;
    endfunction

    // Caller zero-extends the payload, so unused high bits do not disturb the XOR.
    function automatic logic parity_bit(input logic [8:0] data, input int mode);
        logic x;
        x = ^data;
        case (mode)
            PAR_ODD:  return ~x;
            PAR_EVEN: return x;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with one-bit-wider pointers; full/empty come straight from
// the pointer registers so they never see a combinational path from the write side.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           wr_en,
    input  logic [WIDTH-1:0]               wr_data,
    input  logic                           rd_en,
    output logic [WIDTH-1:0]               rd_data,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_wr_s, do_rd_s;

    assign do_wr_s = wr_en && !full;
    assign do_rd_s = rd_en && !empty;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level   = LW'(wr_ptr_q - rd_ptr_q);
    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_wr_s) begin
            wr_ptr_d = wr_ptr_q + (AW+1)'(1'b1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_rd_s) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1'b1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= {(AW+1){1'b0}};
            rd_ptr_q <= {(AW+1){1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_wr_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/uart_tx_fifo_param.sv
// Buffered UART transmitter with configurable frame format and integer baud divider.
// Define UART_TX_CTS_EN to add the cts_n flow-control input.
module uart_tx_fifo_param
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 12000000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                               clk,
    input  logic                               rst,
`ifdef UART_TX_CTS_EN
    input  logic                               cts_n,
`endif
    input  logic [DATA_BITS-1:0]               s_data,
    input  logic                               s_valid,
    output logic                               s_ready,
    output logic                               txd,
    output logic                               busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level
);
    localparam int DIV = calc_div(CLK_FREQ, BAUD);
    localparam int CW  = (DIV < 2) ? 1 : $clog2(DIV);

    if (DIV < 2) begin : g_bad_div
        $error("uart_tx_fifo_param: baud divider below 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_width
        $error("uart_tx_fifo_param: DATA_BITS outside 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx_fifo_param: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_fifo_param: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_fifo_param: FIFO_DEPTH must be a power of two >= 2");
    end

    tx_state_e              state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [3:0]             bit_q, bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   par_q, par_d;
    logic                   txd_q, txd_d;
    logic                   pop_s, pop_ok_s, bit_end_s, cts_ok_s;
    logic                   fifo_full_s, fifo_empty_s;
    logic [DATA_BITS-1:0]   fifo_rd_data_s;

    uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (s_valid),
        .wr_data (s_data),
        .rd_en   (pop_s),
        .rd_data (fifo_rd_data_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s),
        .level   (fifo_level)
    );

`ifdef UART_TX_CTS_EN
    logic [1:0] cts_sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cts_sync_q <= 2'b11;
        end else begin
            cts_sync_q <= {cts_sync_q[0], cts_n};
        end
    end
    assign cts_ok_s = ~cts_sync_q[1];
`else
    assign cts_ok_s = 1'b1;
`endif

    assign s_ready   = ~fifo_full_s;
    assign busy      = (state_q != ST_IDLE);
    assign txd       = txd_q;
    assign pop_ok_s  = ~fifo_empty_s & cts_ok_s;
    assign bit_end_s = (cnt_q == CW'(DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CW{1'b0}};
            bit_q   <= 4'd0;
            shift_q <= {DATA_BITS{1'b0}};
            par_q   <= 1'b0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            txd_q   <= txd_d;
        end
    end

    // Frame sequencing; the STOP exit chains straight into the next START when a word waits.
    always_comb begin
        state_d = state_q;
        pop_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pop_ok_s) begin
                    state_d = ST_START;
                    pop_s   = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_end_s) begin
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (bit_end_s && bit_q == 4'(DATA_BITS - 1)) begin
                    state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (bit_end_s) begin
                    state_d = ST_STOP;
                end else begin
                    state_d = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (bit_end_s && bit_q == 4'(STOP_BITS - 1)) begin
                    if (pop_ok_s) begin
                        state_d = ST_START;
                        pop_s   = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        if (pop_s || bit_end_s || state_q == ST_IDLE) begin
            cnt_d = {CW{1'b0}};
        end else begin
            cnt_d = cnt_q + CW'(1'b1);
        end
        if (state_d != state_q) begin
            bit_d = 4'd0;
        end else if (bit_end_s) begin
            bit_d = bit_q + 4'd1;
        end else begin
            bit_d = bit_q;
        end
        if (pop_s) begin
            shift_d = fifo_rd_data_s;
            par_d   = parity_bit(9'(fifo_rd_data_s), PARITY);
        end else if (state_q == ST_DATA && bit_end_s) begin
            shift_d = shift_q >> 1;
        end else begin
            shift_d = shift_q;
        end
    end

    // Line level is decoded from the next state so txd changes on the same edge as busy.
    always_comb begin
        txd_d = 1'b1;
        case (state_d)
            ST_IDLE:   txd_d = 1'b1;
            ST_START:  txd_d = 1'b0;
            ST_DATA:   txd_d = shift_d[0];
            ST_PARITY: txd_d = par_d;
            ST_STOP:   txd_d = 1'b1;
            default:   txd_d = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// Bench for uart_tx_fifo_param: five differently configured instances checked every
// cycle against a frame-level model, plus literal waveform checks.
module tb_uart_tx_fifo_param;
    localparam int NI    = 5;
    localparam int CLK_F = 12000000;
    localparam int DB_C   [NI] = '{8, 8, 8, 7, 8};
    localparam int PAR_C  [NI] = '{0, 2, 1, 0, 0};
    localparam int SB_C   [NI] = '{1, 1, 1, 2, 1};
    localparam int DEP_C  [NI] = '{16, 16, 16, 16, 4};
    localparam int BAUD_C [NI] = '{115200, 115200, 115200, 115200, 3000000};

    logic            clk;
    logic [NI-1:0]   rst_v, valid_v, rdy_v, txd_v, busy_v, cts_v;
    logic [8:0]      data_a [NI];
    logic [4:0]      lvl_a  [NI];

    int n_checks = 0;
    int n_fail   = 0;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int LW = $clog2(DEP_C[g] + 1);
        logic [LW-1:0] lvl;
        uart_tx_fifo_param #(
            .CLK_FREQ(CLK_F), .BAUD(BAUD_C[g]), .DATA_BITS(DB_C[g]),
            .PARITY(PAR_C[g]), .STOP_BITS(SB_C[g]), .FIFO_DEPTH(DEP_C[g])
        ) u_dut (
            .clk        (clk),
            .rst        (rst_v[g]),
`ifdef UART_TX_CTS_EN
            .cts_n      (cts_v[g]),
`endif
            .s_data     (data_a[g][DB_C[g]-1:0]),
            .s_valid    (valid_v[g]),
            .s_ready    (rdy_v[g]),
            .txd        (txd_v[g]),
            .busy       (busy_v[g]),
            .fifo_level (lvl)
        );
        assign lvl_a[g] = 5'(lvl);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- model: queue of words plus position inside the current frame
    int mq [NI][$];
    int mword [NI];
    int mpos  [NI];
    bit mact  [NI];
    bit ms1   [NI];
    bit ms2   [NI];

    function automatic int div_of(input int i);
        return (CLK_F + BAUD_C[i] / 2) / BAUD_C[i];
    endfunction

    function automatic int flen(input int i);
        return (1 + DB_C[i] + ((PAR_C[i] != 0) ? 1 : 0) + SB_C[i]) * div_of(i);
    endfunction

    function automatic logic exp_txd(input int i);
        int b, w;
        if (!mact[i]) return 1'b1;
        b = mpos[i] / div_of(i);
        w = mword[i];
        if (b == 0) return 1'b0;
        if (b <= DB_C[i]) return w[b-1];
        if (PAR_C[i] != 0 && b == DB_C[i] + 1) return (PAR_C[i] == 2) ? ^w : ~^w;
        return 1'b1;
    endfunction

    task automatic model_step(input int i);
        int pre;
        bit acc, ok;
        if (rst_v[i]) begin
            mq[i].delete();
            mact[i] = 1'b0;
            mpos[i] = 0;
            ms1[i]  = 1'b1;
            ms2[i]  = 1'b1;
        end else begin
            pre = mq[i].size();
            acc = valid_v[i] && (pre < DEP_C[i]);
`ifdef UART_TX_CTS_EN
            ok     = !ms2[i];
            ms2[i] = ms1[i];
            ms1[i] = cts_v[i];
`else
            ok = 1'b1;
`endif
            if (mact[i]) begin
                mpos[i]++;
                if (mpos[i] >= flen(i)) mact[i] = 1'b0;
            end
            if (!mact[i] && pre > 0 && ok) begin
                mword[i] = mq[i].pop_front();
                mact[i]  = 1'b1;
                mpos[i]  = 0;
            end
            if (acc) mq[i].push_back(int'(data_a[i]) & ((1 << DB_C[i]) - 1));
        end
    endtask

    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) model_step(i);
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (rst_v[i]) begin
                check($sformatf("rst_txd%0d", i),   32'(txd_v[i]),  32'd1);
                check($sformatf("rst_busy%0d", i),  32'(busy_v[i]), 32'd0);
                check($sformatf("rst_ready%0d", i), 32'(rdy_v[i]),  32'd1);
                check($sformatf("rst_level%0d", i), 32'(lvl_a[i]),  32'd0);
            end else begin
                check($sformatf("txd%0d", i),   32'(txd_v[i]),  32'(exp_txd(i)));
                check($sformatf("busy%0d", i),  32'(busy_v[i]), 32'(mact[i]));
                check($sformatf("ready%0d", i), 32'(rdy_v[i]),  32'(mq[i].size() < DEP_C[i]));
                check($sformatf("level%0d", i), 32'(lvl_a[i]),  32'(mq[i].size()));
            end
        end
    end

    // ---------------- directed stimulus
    task automatic push1(input int i, input int w);
        bit ok;
        int guard;
        data_a[i]  = 9'(w);
        valid_v[i] = 1'b1;
        guard = 0;
        ok = 1'b0;
        while (!ok && guard < 5000) begin
            @(negedge clk);
            ok = rdy_v[i];
            @(posedge clk);
            #1;
            guard++;
        end
        valid_v[i] = 1'b0;
        if (!ok) check("push_accept", 32'd0, 32'd1);
    endtask

    task automatic watch(input int i, input int nbits, output logic [31:0] bits, output int len);
        int cb, d;
        cb = 0;
        d = div_of(i);
        bits = 32'd0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (busy_v[i]) begin
                if ((cb % d) == d / 2 && (cb / d) < nbits) bits[cb / d] = txd_v[i];
                cb++;
            end else if (cb > 0) begin
                break;
            end
        end
        len = cb;
    endtask

    logic [31:0] bits;
    int          len;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_v   = '1;
        valid_v = '0;
        cts_v   = '0;
        for (int i = 0; i < NI; i++) data_a[i] = 9'd0;
        repeat (3) @(posedge clk);
        #1 rst_v = '0;
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            check("reset_txd",   32'(txd_v[i]),  32'd1);
            check("reset_busy",  32'(busy_v[i]), 32'd0);
            check("reset_ready", 32'(rdy_v[i]),  32'd1);
            check("reset_level", 32'(lvl_a[i]),  32'd0);
        end
        @(posedge clk); #1;

        // 8N1, 0x61
        push1(0, 'h61);
        watch(0, 10, bits, len);
        check("n1_bits", bits, 32'b1011000010);
        check("n1_len", 32'(len), 32'd1040);
        check("n1_idle_txd", 32'(txd_v[0]), 32'd1);
        @(posedge clk); #1;

        // 8E1 and 8O1, 0x61
        push1(1, 'h61);
        watch(1, 11, bits, len);
        check("e1_bits", bits, 32'b11011000010);
        check("e1_len", 32'(len), 32'd1144);
        @(posedge clk); #1;
        push1(2, 'h61);
        watch(2, 11, bits, len);
        check("o1_bits", bits, 32'b10011000010);
        check("o1_len", 32'(len), 32'd1144);
        @(posedge clk); #1;

        // 7 data bits, 2 stop bits, two frames back to back
        push1(3, 'h7F);
        push1(3, 'h00);
        watch(3, 20, bits, len);
        check("d7s2_bits", bits, 32'b11000000001111111110);
        check("d7s2_len", 32'(len), 32'd2080);
        @(posedge clk); #1;

        // depth 4, source holds valid for words 1..6
        fork
            begin : src
                int acc, guard;
                bit seen_full, took;
                acc = 0;
                seen_full = 1'b0;
                for (int w = 1; w <= 6; w++) begin
                    data_a[4]  = 9'(w);
                    valid_v[4] = 1'b1;
                    took = 1'b0;
                    guard = 0;
                    while (!took && guard < 2000) begin
                        @(negedge clk);
                        if (!rdy_v[4] && !seen_full) begin
                            seen_full = 1'b1;
                            check("d4_accepts_at_full", 32'(acc), 32'd5);
                            check("d4_level_at_full", 32'(lvl_a[4]), 32'd4);
                        end
                        took = rdy_v[4];
                        @(posedge clk); #1;
                        guard++;
                    end
                    if (took) acc++;
                    else check("d4_accept", 32'd0, 32'd1);
                end
                valid_v[4] = 1'b0;
                check("d4_ready_dropped", 32'(seen_full), 32'd1);
            end
            begin : mon
                logic [31:0] b4;
                int l4;
                watch(4, 0, b4, l4);
                check("d4_busy_len", 32'(l4), 32'd240);
            end
        join
        @(posedge clk); #1;

        // reset in the middle of bit 3 with three words still queued
        for (int k = 0; k < 4; k++) push1(0, 'h00);
        repeat (3 * 104 + 30) @(posedge clk);
        #1;
        check("pre_rst_txd", 32'(txd_v[0]), 32'd0);
        check("pre_rst_level", 32'(lvl_a[0]), 32'd3);
        rst_v[0] = 1'b1;
        #1;
        check("async_rst_txd", 32'(txd_v[0]), 32'd1);
        check("async_rst_busy", 32'(busy_v[0]), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_v[0] = 1'b0;
        begin : post_rst
            int bc;
            bc = 0;
            for (int c = 0; c < 400; c++) begin
                @(negedge clk);
                if (busy_v[0]) bc++;
            end
            check("post_rst_busy_cycles", 32'(bc), 32'd0);
            check("post_rst_level", 32'(lvl_a[0]), 32'd0);
            check("post_rst_ready", 32'(rdy_v[0]), 32'd1);
        end
        @(posedge clk); #1;

`ifdef UART_TX_CTS_EN
        begin : cts_test
            int lowc, c;
            cts_v[0] = 1'b1;
            repeat (3) @(posedge clk);
            #1;
            push1(0, 'h55);
            push1(0, 'hAA);
            lowc = 0;
            for (int k = 0; k < 200; k++) begin
                @(negedge clk);
                if (!txd_v[0]) lowc++;
            end
            check("cts_hold_low_cycles", 32'(lowc), 32'd0);
            check("cts_hold_level", 32'(lvl_a[0]), 32'd2);
            @(posedge clk); #1;
            cts_v[0] = 1'b0;
            c = 0;
            while (c < 10) begin
                @(negedge clk);
                c++;
                if (!txd_v[0]) break;
            end
            check("cts_start_within_3", 32'(c <= 3), 32'd1);
            repeat (500) @(posedge clk);
            #1 cts_v[0] = 1'b1;
            repeat (1200) @(posedge clk);
            #1;
            check("cts_held_busy", 32'(busy_v[0]), 32'd0);
            check("cts_held_level", 32'(lvl_a[0]), 32'd1);
            cts_v[0] = 1'b0;
            repeat (5) @(posedge clk);
            #1;
            check("cts_resume_busy", 32'(busy_v[0]), 32'd1);
            repeat (1100) @(posedge clk);
            #1;
            check("cts_done_level", 32'(lvl_a[0]), 32'd0);
            check("cts_done_busy", 32'(busy_v[0]), 32'd0);
        end
`endif

        repeat (5) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
